// File: rtl/wb_stage.sv
// wb_stage: single-entry writeback register feeding a two-write-port register
// file. Port 1 writes rd with the primary result; port 2 writes R_HI with the
// high half of long results. Both ports are driven purely from the registered
// entry, so the file commits one edge after the entry was captured.
//
// Upstream contract: mem_valid qualifies the mem_* payload on the edge where it
// is sampled. stall=1 holds the current entry (writes repeat, which is harmless
// because they are identical). flush=1 replaces the entry with a bubble and
// beats stall. There is no back-pressure port; the producer must honour stall.
module wb_stage #(
    parameter int unsigned RETIRE_W = 16,
    parameter logic [3:0]  R_HI     = 4'hF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                stall,
    input  logic                flush,
    input  logic                mem_valid,
    input  logic                mem_wr_en,
    input  logic                mem_is_long,
    input  logic [3:0]          mem_rd,
    input  logic [15:0]         mem_result,
    input  logic [15:0]         mem_hi,
    output logic                WE1,
    output logic                WE2,
    output logic [3:0]          WriteAddress1,
    output logic [3:0]          WriteAddress2,
    output logic [15:0]         WriteData1,
    output logic [15:0]         WriteData2,
    output logic                fwd1_en,
    output logic [3:0]          fwd1_rd,
    output logic [15:0]         fwd1_data,
    output logic                fwd2_en,
    output logic [15:0]         fwd2_data,
    output logic [RETIRE_W-1:0] retire_count
);

    // Registered writeback entry.
    logic        wb_valid;
    logic        wb_wr_en;
    logic        wb_is_long;
    logic [3:0]  wb_rd;
    logic [15:0] wb_result;
    logic [15:0] wb_hi;
    // Set only on the edge that loaded the entry, so a held entry retires once.
    logic        fresh;

    // Decoded write requests for the two register-file ports.
    logic        wr1;
    logic        wr2;
    logic        collide;

    // Entry capture: flush wins over stall; stall holds the entry but clears fresh.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wb_valid   <= 1'b0;
            wb_wr_en   <= 1'b0;
            wb_is_long <= 1'b0;
            wb_rd      <= 4'h0;
            wb_result  <= 16'h0000;
            wb_hi      <= 16'h0000;
            fresh      <= 1'b0;
        end else if (flush) begin
            wb_valid <= 1'b0;
            fresh    <= 1'b0;
        end else if (!stall) begin
            wb_valid   <= mem_valid;
            wb_wr_en   <= mem_wr_en;
            wb_is_long <= mem_is_long;
            wb_rd      <= mem_rd;
            wb_result  <= mem_result;
            wb_hi      <= mem_hi;
            fresh      <= 1'b1;
        end else begin
            fresh <= 1'b0;
        end
    end

    // Retire counter: one count per valid entry, on the edge that ends its first cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            retire_count <= '0;
        end else if (wb_valid && fresh) begin
            retire_count <= retire_count + 1'b1;
        end
    end

    // Port decode: a long op targeting R_HI drops port 1 so R_HI gets only the high half.
    always_comb begin
        collide = wb_is_long && (wb_rd == R_HI);
        wr1     = wb_valid && wb_wr_en && !collide;
        wr2     = wb_valid && wb_is_long;
    end

    // Register-file ports (active-low enables) and decode bypass, zeroed when idle.
    always_comb begin
        WE1           = ~wr1;
        WE2           = ~wr2;
        WriteAddress1 = wr1 ? wb_rd : 4'h0;
        WriteData1    = wr1 ? wb_result : 16'h0000;
        WriteAddress2 = wr2 ? R_HI : 4'h0;
        WriteData2    = wr2 ? wb_hi : 16'h0000;
        fwd1_en       = wr1;
        fwd1_rd       = wr1 ? wb_rd : 4'h0;
        fwd1_data     = wr1 ? wb_result : 16'h0000;
        fwd2_en       = wr2;
        fwd2_data     = wr2 ? wb_hi : 16'h0000;
    end

endmodule

// File: tb/tb_wb_stage.sv
// tb_wb_stage: directed vectors with hand-computed expected port values.
// The driver pushes the expected output vector after each capture edge; a
// separate monitor pops and compares on the following falling edge (or on an
// explicit sample event for asynchronous-reset checks).
module tb_wb_stage;

  localparam int RW = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        stall, flush, mem_valid, mem_wr_en, mem_is_long;
  logic [3:0]  mem_rd;
  logic [15:0] mem_result, mem_hi;
  logic        WE1, WE2, fwd1_en, fwd2_en;
  logic [3:0]  WriteAddress1, WriteAddress2, fwd1_rd;
  logic [15:0] WriteData1, WriteData2, fwd1_data, fwd2_data;
  logic [RW-1:0] retire_count;

  wb_stage #(.RETIRE_W(RW), .R_HI(4'hF)) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .mem_valid(mem_valid), .mem_wr_en(mem_wr_en), .mem_is_long(mem_is_long),
    .mem_rd(mem_rd), .mem_result(mem_result), .mem_hi(mem_hi),
    .WE1(WE1), .WE2(WE2),
    .WriteAddress1(WriteAddress1), .WriteAddress2(WriteAddress2),
    .WriteData1(WriteData1), .WriteData2(WriteData2),
    .fwd1_en(fwd1_en), .fwd1_rd(fwd1_rd), .fwd1_data(fwd1_data),
    .fwd2_en(fwd2_en), .fwd2_data(fwd2_data),
    .retire_count(retire_count)
  );

  // ---------------- scoreboard ----------------
  logic [95:0] exp_q[$];
  string       name_q[$];
  int          checks = 0;
  int          errors = 0;
  event        sample_ev;
  logic [95:0] act;

  assign act = {WE1, WE2, WriteAddress1, WriteAddress2, WriteData1, WriteData2,
                fwd1_en, fwd1_rd, fwd1_data, fwd2_en, fwd2_data,
                {(16-RW){1'b0}}, retire_count};

  // Builds an expected vector from hand values: w = port writes, a/d = address/data.
  function automatic logic [95:0] mk(input logic w1, input logic [3:0] a1,
                                     input logic [15:0] d1, input logic w2,
                                     input logic [3:0] a2, input logic [15:0] d2,
                                     input logic [15:0] rc);
    return {~w1, ~w2, a1, a2, d1, d2, w1, a1, d1, w2, d2, rc};
  endfunction

  logic [95:0] idle_vec;

  // Monitor: compare the DUT against the oldest expected vector.
  always begin
    logic [95:0] e;
    string       n;
    @(negedge clk or sample_ev);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n = name_q.pop_front();
      checks++;
      if (act !== e) begin
        errors++;
        $display("FAIL %s got %h want %h", n, act, e);
      end
    end
  end

  // ---------------- driver ----------------
  task automatic step(input logic r, input logic v, input logic we,
                      input logic lng, input logic [3:0] rd,
                      input logic [15:0] res, input logic [15:0] hi,
                      input logic stl, input logic fl,
                      input logic [95:0] e, input string nm);
    @(negedge clk);
    rst         = r;
    mem_valid   = v;
    mem_wr_en   = we;
    mem_is_long = lng;
    mem_rd      = rd;
    mem_result  = res;
    mem_hi      = hi;
    stall       = stl;
    flush       = fl;
    @(posedge clk);
    #1;
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  task automatic sample_now(input logic [95:0] e, input string nm);
    exp_q.push_back(e);
    name_q.push_back(nm);
    -> sample_ev;
    #1;
  endtask

  logic [15:0] rc;

  initial begin
    stall = 0; flush = 0; mem_valid = 0; mem_wr_en = 0; mem_is_long = 0;
    mem_rd = 0; mem_result = 0; mem_hi = 0;
    idle_vec = 96'h0;
    rc = 16'd0;

    // Reset state, then hold reset across an edge with a valid input.
    @(negedge clk);
    #1;
    sample_now(mk(0, 4'h0, 16'h0, 0, 4'h0, 16'h0, 16'd0), "reset_state");
    step(1, 1, 1, 0, 4'h6, 16'h6666, 16'h0, 0, 0,
         mk(0, 4'h0, 16'h0, 0, 4'h0, 16'h0, 16'd0), "reset_hold");

    // Simple write captured on the first edge after reset release.
    step(0, 1, 1, 0, 4'h3, 16'h1234, 16'h0, 0, 0,
         mk(1, 4'h3, 16'h1234, 0, 4'h0, 16'h0, 16'd0), "simple");
    step(0, 0, 0, 0, 4'h0, 16'h0, 16'h0, 0, 0,
         mk(0, 4'h0, 16'h0, 0, 4'h0, 16'h0, 16'd1), "simple_retire");
    // Long op: both ports.
    step(0, 1, 1, 1, 4'h2, 16'h0010, 16'hABCD, 0, 0,
         mk(1, 4'h2, 16'h0010, 1, 4'hF, 16'hABCD, 16'd1), "long");
    // Collision: port 1 suppressed.
    step(0, 1, 1, 1, 4'hF, 16'h1111, 16'h2222, 0, 0,
         mk(0, 4'h0, 16'h0, 1, 4'hF, 16'h2222, 16'd2), "collision");
    // Long op with wr_en=0 still writes R_HI only.
    step(0, 1, 0, 1, 4'h7, 16'h5555, 16'h6666, 0, 0,
         mk(0, 4'h0, 16'h0, 1, 4'hF, 16'h6666, 16'd3), "long_no_we");
    // Valid entry with no write: retires but drives nothing.
    step(0, 1, 0, 0, 4'h9, 16'h9999, 16'h0, 0, 0,
         mk(0, 4'h0, 16'h0, 0, 4'h0, 16'h0, 16'd4), "no_write");

    // Stall: load rd=5, then hold three cycles with new mem values.
    step(0, 1, 1, 0, 4'h5, 16'h00FF, 16'h0, 0, 0,
         mk(1, 4'h5, 16'h00FF, 0, 4'h0, 16'h0, 16'd5), "stall_load");
    step(0, 1, 1, 1, 4'h8, 16'hBEEF, 16'hCAFE, 1, 0,
         mk(1, 4'h5, 16'h00FF, 0, 4'h0, 16'h0, 16'd6), "stall_1");
    step(0, 1, 1, 0, 4'h9, 16'hDEAD, 16'h0, 1, 0,
         mk(1, 4'h5, 16'h00FF, 0, 4'h0, 16'h0, 16'd6), "stall_2");
    step(0, 1, 1, 0, 4'hA, 16'hF00D, 16'h0, 1, 0,
         mk(1, 4'h5, 16'h00FF, 0, 4'h0, 16'h0, 16'd6), "stall_3");
    step(0, 0, 0, 0, 4'h0, 16'h0, 16'h0, 0, 0,
         mk(0, 4'h0, 16'h0, 0, 4'h0, 16'h0, 16'd6), "stall_release");

    // Flush with stall on a held entry: bubble, count unchanged.
    step(0, 1, 1, 0, 4'h1, 16'h0AAA, 16'h0, 0, 0,
         mk(1, 4'h1, 16'h0AAA, 0, 4'h0, 16'h0, 16'd6), "pre_flush");
    step(0, 1, 1, 0, 4'h2, 16'h0BBB, 16'h0, 1, 0,
         mk(1, 4'h1, 16'h0AAA, 0, 4'h0, 16'h0, 16'd7), "pre_flush_hold");
    step(0, 1, 1, 1, 4'h3, 16'h0CCC, 16'h0DDD, 1, 1,
         mk(0, 4'h0, 16'h0, 0, 4'h0, 16'h0, 16'd7), "flush_stall");
    // Flush without stall drops the incoming entry; it never counts.
    step(0, 1, 1, 1, 4'h4, 16'h0EEE, 16'h0FFF, 0, 1,
         mk(0, 4'h0, 16'h0, 0, 4'h0, 16'h0, 16'd7), "flush_drop");
    step(0, 0, 0, 0, 4'h0, 16'h0, 16'h0, 0, 0,
         mk(0, 4'h0, 16'h0, 0, 4'h0, 16'h0, 16'd7), "flush_idle");

    // Back-to-back writes across the 4-bit retire counter wrap (7 -> 15 -> 0 -> 2).
    rc = 16'd7;
    for (int i = 0; i < 12; i++) begin
      logic [3:0]  rd_i;
      logic [15:0] d_i;
      rd_i = 4'(i);
      d_i  = 16'h0100 + 16'(i);
      step(0, 1, 1, 0, rd_i, d_i, 16'h0, 0, 0,
           mk(1, rd_i, d_i, 0, 4'h0, 16'h0, rc), "wrap_seq");
      rc = (rc + 16'd1) & 16'h000F;
    end
    step(0, 0, 0, 0, 4'h0, 16'h0, 16'h0, 0, 0,
         mk(0, 4'h0, 16'h0, 0, 4'h0, 16'h0, 16'd3), "wrap_end");

    // Asynchronous reset in the middle of a stalled long write.
    step(0, 1, 1, 1, 4'h2, 16'h0010, 16'hABCD, 0, 0,
         mk(1, 4'h2, 16'h0010, 1, 4'hF, 16'hABCD, 16'd3), "async_long");
    step(0, 1, 1, 0, 4'h6, 16'h7777, 16'h0, 1, 0,
         mk(1, 4'h2, 16'h0010, 1, 4'hF, 16'hABCD, 16'd4), "async_long_hold");
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    sample_now(mk(0, 4'h0, 16'h0, 0, 4'h0, 16'h0, 16'd0), "async_rst");
    step(1, 1, 1, 1, 4'h6, 16'h7777, 16'h8888, 1, 0,
         mk(0, 4'h0, 16'h0, 0, 4'h0, 16'h0, 16'd0), "rst_hold_stall");
    step(0, 1, 1, 0, 4'h4, 16'h4444, 16'h0, 0, 0,
         mk(1, 4'h4, 16'h4444, 0, 4'h0, 16'h0, 16'd0), "first_capture");
    step(0, 0, 0, 0, 4'h0, 16'h0, 16'h0, 0, 0,
         mk(0, 4'h0, 16'h0, 0, 4'h0, 16'h0, 16'd1), "first_retire");

    // Drain: bounded wait for the monitor to consume everything.
    for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(negedge clk);
    #1;
    if (exp_q.size() > 0) begin
      $display("FAIL drain got %0d pending want 0", exp_q.size());
      errors += exp_q.size();
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/wb_stage.md
WB_STAGE -- requirements
Module: wb_stage

Interface
REQ-001 SHALL have parameter RETIRE_W, default 16, width of retired-instruction counter.
REQ-002 SHALL have parameter R_HI, default 4'hF, register index receiving high half of long results.
REQ-003 SHALL have port: clk  input  1  sole clock, all state on rising edge.
REQ-004 SHALL have port: rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port: stall  input  1  hold WB contents this cycle.
REQ-006 SHALL have port: flush  input  1  replace captured entry with bubble.
REQ-007 SHALL have ports: mem_valid  input  1;  mem_wr_en  input  1;  mem_is_long  input  1  (instruction writes rd and R_HI).
REQ-008 SHALL have ports: mem_rd  input  4;  mem_result  input  16  (low/primary result);  mem_hi  input  16  (high half).
REQ-009 SHALL have ports: WE1, WE2  output  1 each  register-file write enables, active-low (0 = write).
REQ-010 SHALL have ports: WriteAddress1, WriteAddress2  output  4;  WriteData1, WriteData2  output  16.
REQ-011 SHALL have ports: fwd1_en  output  1;  fwd1_rd  output  4;  fwd1_data  output  16  (bypass of port-1 write to decode).
REQ-012 SHALL have ports: fwd2_en  output  1;  fwd2_data  output  16  (bypass of R_HI write).
REQ-013 SHALL have port: retire_count  output  RETIRE_W  count of valid entries retired.

Function
REQ-014 SHALL hold one registered entry: wb_valid, wb_wr_en, wb_is_long, wb_rd, wb_result, wb_hi, plus fresh flag.
REQ-015 SHALL, on rising edge with flush=1, set wb_valid=0 and fresh=0 regardless of stall.
REQ-016 SHALL, on rising edge with flush=0, stall=0, load entry from mem_* inputs and set fresh=1.
REQ-017 SHALL, on rising edge with flush=0, stall=1, keep entry unchanged and set fresh=0.
REQ-018 SHALL give latency of exactly one cycle: mem_* sampled at edge N drive write ports during cycle N..N+1, register file commits at edge N+1.
REQ-019 SHALL compute wr1 = wb_valid & wb_wr_en & ~(wb_is_long & wb_rd==R_HI); wr2 = wb_valid & wb_is_long.
REQ-020 SHALL drive WE1 = ~wr1, WriteAddress1 = wr1 ? wb_rd : 0, WriteData1 = wr1 ? wb_result : 0.
REQ-021 SHALL drive WE2 = ~wr2, WriteAddress2 = wr2 ? R_HI : 0, WriteData2 = wr2 ? wb_hi : 0.
REQ-022 SHALL, on collision (long op with rd==R_HI), suppress port 1 so R_HI receives wb_hi only; never assert both ports to one address.
REQ-023 SHALL treat wb_is_long as a write regardless of wb_wr_en.
REQ-024 SHALL drive fwd1_en=wr1, fwd1_rd=WriteAddress1, fwd1_data=WriteData1; fwd2_en=wr2, fwd2_data=WriteData2; all combinational from registered state.
REQ-025 SHALL repeat identical writes while stalled (idempotent); no write deasserted by stall.
REQ-026 SHALL increment retire_count by 1 on rising edge when wb_valid=1 and fresh=1, so a stalled entry counts once.
REQ-027 SHALL wrap retire_count from 2^RETIRE_W-1 to 0.
REQ-028 SHALL count bubbles (wb_valid=0) and flushed entries zero times.

Reset
REQ-029 SHALL, while rst=1, asynchronously clear wb_valid, fresh, wb_wr_en, wb_is_long, wb_rd, wb_result, wb_hi, retire_count.
REQ-030 SHALL present after reset: WE1=1, WE2=1, WriteAddress1/2=0, WriteData1/2=0, fwd1_en=0, fwd2_en=0, retire_count=0.
REQ-031 SHALL, on reset mid-stall or mid-long-write, discard held entry; no write issued after rst rises.
REQ-032 SHALL capture first entry on first rising edge after rst falls, subject to stall/flush.

Verification
REQ-033 Simple write: mem_valid=1, mem_wr_en=1, rd=3, result=16'h1234 -> next cycle WE1=0, WriteAddress1=3, WriteData1=16'h1234, WE2=1, fwd1_en=1; retire_count 0->1 next edge.
REQ-034 Long op: is_long=1, rd=2, result=16'h0010, hi=16'hABCD -> WE1=0 addr 2 data 16'h0010; WE2=0 addr 15 data 16'hABCD.
REQ-035 Collision: is_long=1, rd=15, result=16'h1111, hi=16'h2222 -> WE1=1, addr1=0; WE2=0, addr 15, data 16'h2222.
REQ-036 Stall: load rd=5 data 16'h00FF, hold stall=1 three cycles with new mem_* values -> outputs unchanged four cycles; retire_count advances by exactly 1.
REQ-037 Flush with stall: flush=1, stall=1 one edge -> WE1=WE2=1, fwd*_en=0, retire_count unchanged.
REQ-038 Async reset during long write: assert rst between edges -> WE1=WE2=1, retire_count=0 immediately, without clock edge.
